mult_div_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Its operands come directly from the register file read ports (readData1 = srcA, readData2 = srcB). Its hi/lo outputs feed the write-back mux, so MFHI/MFLO results return to the register file write port. It executes MULT, MULTU, DIV and DIVU at one bit per clock, and supports MTHI/MTLO direct writes.

---
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit.sv | 127 ++++++++++++
 tb/tb_mult_div_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake/data bundle between the datapath and the HI/LO multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             hiWrite;
  logic             loWrite;
  logic [WIDTH-1:0] writeData;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Datapath side: issues operations and MTHI/MTLO, reads HI/LO.
  modport master (
    output start, op, srcA, srcB, hiWrite, loWrite, writeData,
    input  busy, done, hi, lo
  );

  // Unit side.
  modport slave (
    input  start, op, srcA, srcB, hiWrite, loWrite, writeData,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per clock, with architectural
// HI/LO registers and MTHI/MTLO direct writes.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clock,
  input  logic            rst,
  mult_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [1:0]         opReg;
  logic [WIDTH-1:0]   opnd;      // multiplicand (mul) or divisor (div), unsigned
  logic [2*WIDTH-1:0] acc;       // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [CW-1:0]      cnt;
  logic               signA, signB, divZero;
  logic [WIDTH-1:0]   origA;
  logic [WIDTH-1:0]   hiReg, loReg;
  logic               busyReg, doneReg;

  // Start-time operand conditioning: magnitudes for signed ops.
  logic             isSigned, sA, sB;
  logic [WIDTH-1:0] absA, absB;
  always_comb begin
    isSigned = ~bus.op[0];
    sA       = isSigned & bus.srcA[WIDTH-1];
    sB       = isSigned & bus.srcB[WIDTH-1];
    absA     = sA ? -bus.srcA : bus.srcA;
    absB     = sB ? -bus.srcB : bus.srcB;
  end

  // One iteration of shift-add (mul) or restoring shift-subtract (div).
  logic [WIDTH:0]     mulSum, divTrial;
  logic [2*WIDTH-1:0] accNext;
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    divTrial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    accNext  = acc;
    if (!opReg[1])
      accNext = {mulSum, acc[WIDTH-1:1]};
    else if (!divTrial[WIDTH])
      accNext = {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      accNext = {acc[2*WIDTH-2:0], 1'b0};
  end

  // Final sign correction; unsigned ops never record a sign so this is a no-op.
  logic               fixSigned, negPQ;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;
  always_comb begin
    fixSigned = ~opReg[0];
    negPQ     = fixSigned & (signA ^ signB);
    prodFix   = negPQ ? -acc : acc;
    quotFix   = negPQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remFix    = (fixSigned & signA) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered busy/done and HI/LO update.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      opReg   <= '0;
      opnd    <= '0;
      acc     <= '0;
      cnt     <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      divZero <= 1'b0;
      origA   <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opReg   <= bus.op;
            signA   <= sA;
            signB   <= sB;
            divZero <= bus.op[1] & (bus.srcB == '0);
            origA   <= bus.srcA;
            opnd    <= bus.op[1] ? absB : absA;
            acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? absA : absB)};
            cnt     <= '0;
            busyReg <= 1'b1;
            state   <= RUN;
          end else begin
            if (bus.hiWrite) hiReg <= bus.writeData;
            if (bus.loWrite) loReg <= bus.writeData;
          end
        end
        RUN: begin
          acc <= accNext;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!opReg[1]) begin
            hiReg <= prodFix[2*WIDTH-1:WIDTH];
            loReg <= prodFix[WIDTH-1:0];
          end else if (divZero) begin
            hiReg <= origA;
            loReg <= '1;
          end else begin
            hiReg <= remFix;
            loReg <= quotFix;
          end
          doneReg <= 1'b1;
          busyReg <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed vectors, assertion checks.
module tb_mult_div_unit;
  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc;

  mult_div_unit_if #(.WIDTH(32)) bus ();
  mult_div_unit #(.WIDTH(32)) dut (.clock(clock), .rst(rst), .bus(bus.slave));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an operation for one edge (optionally with a concurrent MTHI).
  task automatic startOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic hw, input logic [31:0] wd);
    bus.start = 1'b1; bus.op = o; bus.srcA = a; bus.srcB = b;
    bus.hiWrite = hw; bus.writeData = wd;
    tick();
    bus.start = 1'b0; bus.hiWrite = 1'b0;
    bus.srcA = '0; bus.srcB = '0; bus.op = 2'b00;
  endtask

  // Count edges until done, bounded.
  task automatic waitDone(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    bus.start = 0; bus.op = 0; bus.srcA = 0; bus.srcB = 0;
    bus.hiWrite = 0; bus.loWrite = 0; bus.writeData = 0;
    #12;
    check("rst_hi",   bus.hi,   32'h0);
    check("rst_lo",   bus.lo,   32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);
    rst = 1'b0;
    tick();

    // MULTU max*max
    startOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0);
    check("multu_busy", {31'b0, bus.busy}, 32'h1);
    check("multu_hold", bus.hi, 32'h0);
    waitDone(cyc);
    check("multu_lat",  cyc, 33);
    check("multu_bsy0", {31'b0, bus.busy}, 32'h0);
    check("multu_hi",   bus.hi, 32'hFFFFFFFE);
    check("multu_lo",   bus.lo, 32'h00000001);
    tick();
    check("done_pulse", {31'b0, bus.done}, 32'h0);

    // MULT -3*7
    startOp(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 32'h0);
    waitDone(cyc);
    check("mult_lat", cyc, 33);
    check("mult_hi",  bus.hi, 32'hFFFFFFFF);
    check("mult_lo",  bus.lo, 32'hFFFFFFEB);
    tick();

    // DIV -7/2
    startOp(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 32'h0);
    waitDone(cyc);
    check("div_lat", cyc, 33);
    check("div_lo",  bus.lo, 32'hFFFFFFFD);
    check("div_hi",  bus.hi, 32'hFFFFFFFF);
    tick();

    // DIVU by zero
    startOp(2'b11, 32'd100, 32'd0, 1'b0, 32'h0);
    waitDone(cyc);
    check("dz_lat", cyc, 33);
    check("dz_lo",  bus.lo, 32'hFFFFFFFF);
    check("dz_hi",  bus.hi, 32'd100);
    tick();

    // DIV overflow
    startOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0);
    waitDone(cyc);
    check("ovf_lo", bus.lo, 32'h80000000);
    check("ovf_hi", bus.hi, 32'h0);
    tick();

    // DIVU 10/3 with a start and MTHI injected mid-run
    startOp(2'b11, 32'd10, 32'd3, 1'b0, 32'h0);
    repeat (4) tick();
    bus.start = 1'b1; bus.op = 2'b01; bus.srcA = 32'd2; bus.srcB = 32'd2;
    bus.hiWrite = 1'b1; bus.writeData = 32'h1234;
    tick();
    bus.start = 1'b0; bus.hiWrite = 1'b0;
    check("busy_mthi", bus.hi, 32'h0);
    check("busy_still", {31'b0, bus.busy}, 32'h1);
    waitDone(cyc);
    check("ign_lat", cyc, 28);
    check("ign_lo",  bus.lo, 32'd3);
    check("ign_hi",  bus.hi, 32'd1);

    // Back-to-back: start in the done cycle, MULTU 0x10000^2
    startOp(2'b01, 32'h00010000, 32'h00010000, 1'b0, 32'h0);
    check("b2b_busy", {31'b0, bus.busy}, 32'h1);
    waitDone(cyc);
    check("b2b_lat", cyc, 33);
    check("b2b_hi",  bus.hi, 32'h1);
    check("b2b_lo",  bus.lo, 32'h0);
    tick();

    // MTLO in idle
    bus.loWrite = 1'b1; bus.writeData = 32'hCAFEBABE;
    tick();
    bus.loWrite = 1'b0;
    check("mtlo_lo",   bus.lo, 32'hCAFEBABE);
    check("mtlo_done", {31'b0, bus.done}, 32'h0);
    check("mtlo_hi",   bus.hi, 32'h1);

    // start wins over a simultaneous MTHI
    startOp(2'b01, 32'd3, 32'd4, 1'b1, 32'h0000DEAD);
    check("sw_hi_hold", bus.hi, 32'h1);
    waitDone(cyc);
    check("sw_hi", bus.hi, 32'h0);
    check("sw_lo", bus.lo, 32'd12);
    tick();

    // Asynchronous reset mid-operation
    startOp(2'b01, 32'd5, 32'd6, 1'b0, 32'h0);
    repeat (9) tick();
    rst = 1'b1;
    #1;
    check("arst_lo",   bus.lo, 32'h0);
    check("arst_hi",   bus.hi, 32'h0);
    check("arst_busy", {31'b0, bus.busy}, 32'h0);
    check("arst_done", {31'b0, bus.done}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    startOp(2'b01, 32'd5, 32'd6, 1'b0, 32'h0);
    waitDone(cyc);
    check("post_lat", cyc, 33);
    check("post_lo",  bus.lo, 32'd30);
    check("post_hi",  bus.hi, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
